// File: rtl/dpram_port_arbiter.sv
// Two-client round-robin arbiter for one DPRAM port, with read-data return routing.
// Optional burst lock (LOCK0/LOCK1, burst counter) is built when DPRAM_ARB_LOCK_EN is defined.
module dpram_port_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 16,
    parameter int RD_LATENCY = 2,
    parameter int MAX_BURST  = 8
) (
    input  logic              CLK,
    input  logic              SR_N,
    input  logic              REQ0,
    input  logic              REQ1,
    input  logic              WE0,
    input  logic              WE1,
    input  logic [ADDR_W-1:0] ADDR0,
    input  logic [ADDR_W-1:0] ADDR1,
    input  logic [DATA_W-1:0] WDATA0,
    input  logic [DATA_W-1:0] WDATA1,
`ifdef DPRAM_ARB_LOCK_EN
    input  logic              LOCK0,
    input  logic              LOCK1,
`endif
    output logic              GNT0,
    output logic              GNT1,
    output logic              RVALID0,
    output logic              RVALID1,
    output logic [DATA_W-1:0] RDATA0,
    output logic [DATA_W-1:0] RDATA1,
    output logic              MEM_EN,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA
);

    logic                  gnt0_q, gnt0_d;
    logic                  gnt1_q, gnt1_d;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
    logic                  last_q, last_d;
    logic [RD_LATENCY-1:0] rv0_q, rv0_d;
    logic [RD_LATENCY-1:0] rv1_q, rv1_d;

    logic elig0, elig1;
    logic sel0, sel1;
    logic hold0, hold1;
    logic rd_issue;

`ifdef DPRAM_ARB_LOCK_EN
    // Wide enough to reach MAX_BURST = 16.
    localparam int CW = 5;
    logic [CW-1:0] burst_q, burst_d;
    logic          lock_ok;
`endif

    always_comb begin
`ifdef DPRAM_ARB_LOCK_EN
        lock_ok = burst_q < CW'(MAX_BURST);
        hold0   = gnt0_q & LOCK0 & lock_ok;
        hold1   = gnt1_q & LOCK1 & lock_ok;
`else
        hold0   = 1'b0;
        hold1   = 1'b0;
`endif
        elig0 = REQ0 & (~gnt0_q | hold0);
        elig1 = REQ1 & (~gnt1_q | hold1);
        // A held lock overrides the round-robin pointer.
        sel0  = elig0 & ~(elig1 & hold1) & (~elig1 | hold0 | last_q);
        sel1  = elig1 & ~sel0;
    end

    always_comb begin
        gnt0_d      = sel0;
        gnt1_d      = sel1;
        mem_en_d    = sel0 | sel1;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        last_d      = last_q;
        if (sel0) begin
            mem_we_d    = WE0;
            mem_addr_d  = ADDR0;
            mem_wdata_d = WDATA0;
            last_d      = 1'b0;
        end else if (sel1) begin
            mem_we_d    = WE1;
            mem_addr_d  = ADDR1;
            mem_wdata_d = WDATA1;
            last_d      = 1'b1;
        end
    end

    // While MEM_EN is high, last_q names the client that owns the access.
    always_comb begin
        rd_issue = mem_en_q & ~mem_we_q;
        rv0_d    = (rv0_q << 1) | RD_LATENCY'(rd_issue & ~last_q);
        rv1_d    = (rv1_q << 1) | RD_LATENCY'(rd_issue & last_q);
    end

`ifdef DPRAM_ARB_LOCK_EN
    always_comb begin
        if (!(sel0 | sel1)) begin
            burst_d = '0;
        end else if ((sel1 == last_q) && (burst_q != '0)) begin
            burst_d = burst_q + CW'(1);
        end else begin
            burst_d = CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!SR_N) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (!SR_N) begin
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            last_q      <= 1'b1;
            rv0_q       <= '0;
            rv1_q       <= '0;
        end else begin
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            last_q      <= last_d;
            rv0_q       <= rv0_d;
            rv1_q       <= rv1_d;
        end
    end

    assign GNT0      = gnt0_q;
    assign GNT1      = gnt1_q;
    assign MEM_EN    = mem_en_q;
    assign MEM_WE    = mem_we_q;
    assign MEM_ADDR  = mem_addr_q;
    assign MEM_WDATA = mem_wdata_q;
    assign RVALID0   = rv0_q[RD_LATENCY-1];
    assign RVALID1   = rv1_q[RD_LATENCY-1];
    assign RDATA0    = MEM_RDATA;
    assign RDATA1    = MEM_RDATA;

endmodule
